// File: rtl/keccak_round_sched_pkg.sv
// keccak_ctrl_pkg: shared FSM states, step ordinals and widths for the Keccak round scheduler.
package keccak_ctrl_pkg;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, NEXT, FINISH} state_t;

    localparam int ROUND_W = 5;
    localparam int STEP_W = 3;
    localparam int DEFAULT_ROUNDS = 24;

    localparam logic [STEP_W-1:0] STEP_THETA = 3'd0;
    localparam logic [STEP_W-1:0] STEP_RHO = 3'd1;
    localparam logic [STEP_W-1:0] STEP_PI = 3'd2;
    localparam logic [STEP_W-1:0] STEP_CHI = 3'd3;
    localparam logic [STEP_W-1:0] STEP_IOTA = 3'd4;

endpackage

// File: rtl/keccak_round_sched_if.sv
// keccak_round_sched_if: scheduler bundle; master is the requester/step-unit side, slave is the scheduler.
interface keccak_round_sched_if #(
    parameter int NUM_STEPS = 5
);
    import keccak_ctrl_pkg::*;

    logic                 start;
    logic [NUM_STEPS-1:0] step_done;
    logic                 busy;
    logic                 done;
    logic                 step_clr;
    logic [NUM_STEPS-1:0] step_en;
    logic [STEP_W-1:0]    step_idx;
    logic [ROUND_W-1:0]   round_idx;
    logic                 mem_sel;
    logic                 err;

    modport master (
        output start, step_done,
        input  busy, done, step_clr, step_en, step_idx, round_idx, mem_sel, err
    );

    modport slave (
        input  start, step_done,
        output busy, done, step_clr, step_en, step_idx, round_idx, mem_sel, err
    );

endinterface

// File: rtl/keccak_round_sched_watchdog.sv
// keccak_step_watchdog: counts WAIT cycles of the active step and flags the cycle that reaches the limit.
module keccak_step_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic expired
);

    logic [7:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (run) cnt <= cnt + 8'd1;
    end

    // cnt holds completed WAIT cycles, so the limit-th WAIT cycle sees TIMEOUT_CYCLES-1
    assign expired = run && (cnt == 8'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/keccak_round_sched.sv
// keccak_round_sched: sequences the Keccak step units over NUM_ROUNDS rounds with ping-pong bank select.
// Optional step watchdog enabled by defining KECCAK_SCHED_WATCHDOG_EN.
module keccak_round_sched
    import keccak_ctrl_pkg::*;
#(
    parameter int NUM_ROUNDS = DEFAULT_ROUNDS,
    parameter int NUM_STEPS = 5,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic clk,
    input logic rst,
    keccak_round_sched_if.slave bus
);

    if (NUM_ROUNDS < 1 || NUM_ROUNDS > 31 || NUM_STEPS < 1 || NUM_STEPS > 8 ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_param
        $error("keccak_round_sched: parameter out of range");
    end

    state_t              state, nxt;
    logic [STEP_W-1:0]   step_q;
    logic [ROUND_W-1:0]  round_q;
    logic                sel_q;
    logic                cur_done, last_step, last_round, expired, accept;

    assign cur_done = bus.step_done[step_q];
    assign last_step = step_q == STEP_W'(NUM_STEPS - 1);
    assign last_round = round_q == ROUND_W'(NUM_ROUNDS - 1);
    assign accept = (state == IDLE) && bus.start;

`ifdef KECCAK_SCHED_WATCHDOG_EN
    logic err_q;

    keccak_step_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
        .clk(clk),
        .rst(rst),
        .clr(state == ISSUE),
        .run(state == WAIT),
        .expired(expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else if (accept) err_q <= 1'b0;
        else if (state == WAIT && !cur_done && expired) err_q <= 1'b1;
    end

    assign bus.err = err_q;
`else
    assign expired = 1'b0;
    assign bus.err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = bus.start ? ISSUE : IDLE;
            ISSUE:   nxt = WAIT;
            WAIT:    nxt = cur_done ? NEXT : (expired ? FINISH : WAIT);
            NEXT:    nxt = (last_step && last_round) ? FINISH : ISSUE;
            FINISH:  nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // indices and bank select persist after FINISH until the next accepted start
    always_ff @(posedge clk or posedge rst) begin
        if (rst || accept) begin
            step_q <= '0;
            round_q <= '0;
            sel_q <= 1'b0;
        end else if (state == NEXT) begin
            sel_q <= ~sel_q;
            step_q <= last_step ? (last_round ? step_q : '0) : step_q + 1'b1;
            round_q <= (last_step && !last_round) ? round_q + 1'b1 : round_q;
        end
    end

    always_comb begin
        bus.busy = state != IDLE;
        bus.done = state == FINISH;
        bus.step_clr = state == ISSUE;
        bus.step_en = (state == WAIT) ? (NUM_STEPS'(1) << step_q) : '0;
        bus.step_idx = step_q;
        bus.round_idx = round_q;
        bus.mem_sel = sel_q;
    end

endmodule

// File: tb/tb_keccak_round_sched.sv
// tb_keccak_round_sched: table-driven checks of the round scheduler against model step units.
module tb_keccak_round_sched;

    logic clk = 1'b0;
    logic rst = 1'b1;

    keccak_round_sched_if #(.NUM_STEPS(5)) bus ();

    keccak_round_sched dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // model step unit: done on the d_len-th enabled cycle, plus noise on inactive bits
    int         d_len = 3;
    logic [4:0] noise = '0;
    logic       hang = 1'b0;
    int         ucnt = 0;

    always @(posedge clk) begin
        if (bus.step_clr) ucnt <= 0;
        else if (|bus.step_en) ucnt <= ucnt + 1;
    end

    assign bus.step_done = ((!hang && ucnt == d_len - 1) ? bus.step_en : 5'b0) | (noise & ~bus.step_en);

    int cyc = 0, k = 0, clr_cnt = 0, busy_cnt = 0, done_cnt = 0, oh_bad = 0, ord_bad = 0;
    int last_done_cyc = 0, gap = 0;

    always @(negedge clk) begin
        cyc++;
        if (bus.busy) busy_cnt++;
        if (bus.done) begin
            done_cnt++;
            gap = cyc - last_done_cyc;
            last_done_cyc = cyc;
        end
        if (bus.step_en != 5'b0 && bus.step_en != (5'b1 << bus.step_idx)) oh_bad++;
        if (bus.step_en != 5'b0 && bus.step_clr) oh_bad++;
        if (bus.step_clr) begin
            if (bus.round_idx != 5'((k % 120) / 5) || bus.step_idx != 3'(k % 5) || bus.mem_sel != k[0])
                ord_bad++;
            k++;
            clr_cnt++;
        end
    end

    int total = 0, bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_stats();
        k = 0;
        clr_cnt = 0;
        busy_cnt = 0;
        done_cnt = 0;
        oh_bad = 0;
        ord_bad = 0;
    endtask

    // returns the number of edges from the start-sampling edge to the edge ending FINISH
    task automatic run_perm(input int d, input logic [4:0] nz, input int poke, output int lat);
        d_len = d;
        noise = nz;
        clear_stats();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            bus.start = (lat == poke);
        end while (!bus.done && lat < 3000);
        bus.start = 1'b0;
        lat++;
        repeat (4) @(negedge clk);
    endtask

    task automatic chk_idle_outputs(input string name);
        chk({name, "_busy"}, int'(bus.busy), 0);
        chk({name, "_ctl"}, int'({bus.done, bus.step_clr, bus.step_en, bus.err}), 0);
        chk({name, "_idx"}, int'({bus.step_idx, bus.round_idx, bus.mem_sel}), 0);
    endtask

    typedef struct {
        int         d;
        logic [4:0] nz;
        int         poke;
        int         exp_lat;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int lat, nd, w;
        vecs[0] = '{3, 5'b00000, 0, 601};
        vecs[1] = '{1, 5'b00000, 0, 361};
        vecs[2] = '{5, 5'b00000, 0, 841};
        vecs[3] = '{3, 5'b01000, 0, 601};
        vecs[4] = '{2, 5'b11110, 0, 481};
        vecs[5] = '{3, 5'b00000, 100, 601};

        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        chk_idle_outputs("reset");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_no_start_busy", int'(bus.busy), 0);

        for (int i = 0; i < 6; i++) begin
            run_perm(vecs[i].d, vecs[i].nz, vecs[i].poke, lat);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            chk($sformatf("v%0d_busy_cycles", i), busy_cnt, vecs[i].exp_lat);
            chk($sformatf("v%0d_done_pulses", i), done_cnt, 1);
            chk($sformatf("v%0d_step_clr", i), clr_cnt, 120);
            chk($sformatf("v%0d_order", i), ord_bad, 0);
            chk($sformatf("v%0d_onehot", i), oh_bad, 0);
            chk($sformatf("v%0d_round_end", i), int'(bus.round_idx), 23);
            chk($sformatf("v%0d_step_end", i), int'(bus.step_idx), 4);
            chk($sformatf("v%0d_mem_sel_end", i), int'(bus.mem_sel), 0);
            chk($sformatf("v%0d_busy_after", i), int'(bus.busy), 0);
        end
        noise = '0;
        d_len = 3;

        // start held high: back-to-back permutations
        clear_stats();
        @(negedge clk);
        bus.start = 1'b1;
        nd = 0;
        w = 0;
        do begin
            @(negedge clk);
            w++;
            if (bus.done) nd++;
        end while (nd < 2 && w < 3000);
        bus.start = 1'b0;
        @(negedge clk);
        chk("b2b_gap", gap, 602);
        repeat (700) @(negedge clk);
        chk("b2b_done_pulses", done_cnt, 2);
        chk("b2b_step_clr", clr_cnt, 240);
        chk("b2b_order", ord_bad, 0);

        // asynchronous reset in the middle of a permutation
        clear_stats();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (249) @(negedge clk);
        chk("midrst_busy_before", int'(bus.busy), 1);
        #1 rst = 1'b1;
        #1 chk_idle_outputs("midrst_async");
        #21 rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("midrst_no_done", done_cnt, 0);
        chk("midrst_idle", int'(bus.busy), 0);
        run_perm(3, 5'b00000, 0, lat);
        chk("midrst_rerun_latency", lat, 601);
        chk("midrst_rerun_done", done_cnt, 1);

`ifdef KECCAK_SCHED_WATCHDOG_EN
        hang = 1'b1;
        run_perm(3, 5'b00000, 0, lat);
        chk("wd_latency", lat, 257);
        chk("wd_err", int'(bus.err), 1);
        chk("wd_done_pulses", done_cnt, 1);
        chk("wd_step_clr", clr_cnt, 1);
        chk("wd_step_en_off", int'(bus.step_en), 0);
        hang = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("wd_err_cleared", int'(bus.err), 0);
        w = 0;
        while (!bus.done && w < 3000) begin
            @(negedge clk);
            w++;
        end
        chk("wd_rerun_err", int'(bus.err), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
